// File: rtl/instr_fetch_cache.sv
// Direct-mapped instruction fetch cache. A hit returns an ISSUE_W-wide fetch group one cycle after the request.
// A miss refills the whole line from memory, one word per beat, and then answers from the refilled line.
module instr_fetch_cache #(
    parameter int ISSUE_W    = 2,
    parameter int LINE_WORDS = 4,
    parameter int NUM_SETS   = 64,
    parameter int ADDR_W     = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_req_vld,
    input  logic [ADDR_W-1:0]       i_req_addr,
    output logic                    o_req_rdy,
    output logic                    o_rsp_vld,
    output logic [32*ISSUE_W-1:0]   o_rsp_dat,
    output logic [ISSUE_W-1:0]      o_rsp_mask,
    input  logic                    i_flush,
    output logic                    o_mem_req_vld,
    output logic [ADDR_W-1:0]       o_mem_req_addr,
    input  logic                    i_mem_req_rdy,
    input  logic                    i_mem_rsp_vld,
    input  logic [31:0]             i_mem_rsp_dat
);
    localparam int WB      = $clog2(LINE_WORDS);
    localparam int IB      = $clog2(NUM_SETS);
    localparam int WW      = (WB > 0) ? WB : 1;
    localparam int IW      = (IB > 0) ? IB : 1;
    localparam int DAW     = ((WB + IB) > 0) ? (WB + IB) : 1;
    localparam int WORD_LSB = 2;
    localparam int IDX_LSB = 2 + WB;
    localparam int TAG_LSB = 2 + WB + IB;
    localparam int TAG_W   = ADDR_W - TAG_LSB;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MISS_REQ = 2'd1,
        ST_REFILL   = 2'd2,
        ST_RESP     = 2'd3
    } state_t;

    function automatic logic [WW-1:0] addr_word(input logic [ADDR_W-1:0] a);
        return WW'((a >> WORD_LSB) & ADDR_W'(LINE_WORDS - 1));
    endfunction

    function automatic logic [IW-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return IW'((a >> IDX_LSB) & ADDR_W'(NUM_SETS - 1));
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return TAG_W'(a >> TAG_LSB);
    endfunction

    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
        return (a >> IDX_LSB) << IDX_LSB;
    endfunction

    state_t                 state_r, state_s;
    logic [ADDR_W-1:0]      addr_r;
    logic [ADDR_W-1:0]      mem_req_addr_r;
    logic [WW-1:0]          cnt_r;
    logic                   flush_pend_r;
    logic [NUM_SETS-1:0]    valid_r;
    logic [TAG_W-1:0]       tag_mem [NUM_SETS];
    logic [31:0]            data_mem [NUM_SETS*LINE_WORDS];
    logic                   rsp_vld_r;
    logic [32*ISSUE_W-1:0]  rsp_dat_r, rsp_dat_s;
    logic [ISSUE_W-1:0]     rsp_mask_r, rsp_mask_s;

    logic                   req_fire_s, hit_s, beat_s, last_beat_s, fill_done_s, rsp_load_s;
    logic [IW-1:0]          req_idx_s, lat_idx_s, line_idx_s;
    logic [WW-1:0]          off_s;
    logic [TAG_W-1:0]       req_tag_s;

    assign o_req_rdy      = (state_r == ST_IDLE) && !i_flush;
    assign req_fire_s     = i_req_vld && o_req_rdy;
    assign req_idx_s      = addr_idx(i_req_addr);
    assign req_tag_s      = addr_tag(i_req_addr);
    assign lat_idx_s      = addr_idx(addr_r);
    assign hit_s          = valid_r[req_idx_s] && (tag_mem[req_idx_s] == req_tag_s);
    assign beat_s         = (state_r == ST_REFILL) && i_mem_rsp_vld;
    assign last_beat_s    = beat_s && (cnt_r == WW'(LINE_WORDS - 1));
    // A flush seen at any point of the refill, including its last beat, suppresses the response.
    assign fill_done_s    = last_beat_s && !flush_pend_r && !i_flush;
    assign rsp_load_s     = (req_fire_s && hit_s) || fill_done_s;
    assign line_idx_s     = (state_r == ST_IDLE) ? req_idx_s : lat_idx_s;
    assign off_s          = (state_r == ST_IDLE) ? addr_word(i_req_addr) : addr_word(addr_r);
    assign o_mem_req_vld  = (state_r == ST_MISS_REQ);
    assign o_mem_req_addr = mem_req_addr_r;
    assign o_rsp_vld      = rsp_vld_r;
    assign o_rsp_dat      = rsp_dat_r;
    assign o_rsp_mask     = rsp_mask_r;

    // Next-state logic of the fetch controller.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_fire_s && !hit_s) state_s = ST_MISS_REQ;
                else                      state_s = ST_IDLE;
            end
            ST_MISS_REQ: begin
                if (i_mem_req_rdy) state_s = ST_REFILL;
                else               state_s = ST_MISS_REQ;
            end
            ST_REFILL: begin
                if (last_beat_s) state_s = fill_done_s ? ST_RESP : ST_IDLE;
                else             state_s = ST_REFILL;
            end
            ST_RESP:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Fetch group assembly; during the last refill beat the incoming word bypasses the array.
    always_comb begin
        int          pos;
        logic [31:0] word;
        pos        = 0;
        word       = 32'h0;
        rsp_dat_s  = '0;
        rsp_mask_s = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            pos = int'(off_s) + k;
            if (pos < LINE_WORDS) begin
                if (beat_s && (pos == int'(cnt_r))) word = i_mem_rsp_dat;
                else word = data_mem[DAW'(int'(line_idx_s) * LINE_WORDS + pos)];
            end else begin
                word = 32'h0;
            end
            rsp_dat_s[32*k +: 32] = word;
            rsp_mask_s[k]         = (word != 32'h0);
        end
    end

    // Controller state, latched miss address, refill counter and pending-flush flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r        <= ST_IDLE;
            addr_r         <= '0;
            mem_req_addr_r <= '0;
            cnt_r          <= '0;
            flush_pend_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            if (req_fire_s && !hit_s) begin
                addr_r         <= i_req_addr;
                mem_req_addr_r <= line_base(i_req_addr);
                flush_pend_r   <= 1'b0;
            end else if (i_flush && ((state_r == ST_MISS_REQ) || (state_r == ST_REFILL))) begin
                flush_pend_r   <= 1'b1;
            end else begin
                flush_pend_r   <= flush_pend_r;
            end
            if (req_fire_s && !hit_s) cnt_r <= '0;
            else if (last_beat_s)     cnt_r <= '0;
            else if (beat_s)          cnt_r <= cnt_r + 1'b1;
            else                      cnt_r <= cnt_r;
        end
    end

    // Line valid bits; a flush wins over a completing refill.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)         valid_r <= '0;
        else if (i_flush)     valid_r <= '0;
        else if (fill_done_s) valid_r[lat_idx_s] <= 1'b1;
        else                  valid_r <= valid_r;
    end

    // Registered response; data and mask hold while no response is pending.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp_vld_r  <= 1'b0;
            rsp_dat_r  <= '0;
            rsp_mask_r <= '0;
        end else begin
            rsp_vld_r <= rsp_load_s;
            if (rsp_load_s) begin
                rsp_dat_r  <= rsp_dat_s;
                rsp_mask_r <= rsp_mask_s;
            end else begin
                rsp_dat_r  <= rsp_dat_r;
                rsp_mask_r <= rsp_mask_r;
            end
        end
    end

    // Tag and data arrays are written only by refill beats and carry no reset.
    always_ff @(posedge i_clk) begin
        if (beat_s) data_mem[DAW'(int'(lat_idx_s) * LINE_WORDS + int'(cnt_r))] <= i_mem_rsp_dat;
        if (last_beat_s) tag_mem[lat_idx_s] <= addr_tag(addr_r);
    end

endmodule
